// File: rtl/systolic_nxn_ws.sv
// N x N weight-stationary systolic matrix-vector engine.
// Define SYSTOLIC_SATURATE_EN for clamping instead of wrapping arithmetic.
module systolic_nxn_ws #(
  parameter int N        = 2,
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [N*WIDTH-1:0] w_row,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] a_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] y_out,
  output logic               busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(2*N+1);
  localparam int D  = 2*N;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  typedef logic signed [WIDTH-1:0] dat_t;

`ifdef SYSTOLIC_SATURATE_EN
  localparam logic signed [2*WIDTH-1:0] TMAX =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] TMIN =
    {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] SMAX =
    {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] SMIN =
    {2'b11, {(WIDTH-1){1'b0}}};
`endif

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [OW-1:0] occ;
  logic [D-1:0]  vld;
  dat_t wm   [N][N];
  dat_t a_r  [N];
  dat_t sk   [N][N];
  dat_t a_h  [N][N];
  dat_t ps   [N][N];
  dat_t dk   [N][N];
  dat_t pe_a [N][N];
  dat_t pe_s [N][N];
  logic stall, adv, w_hs, in_hs, out_hs;

  function automatic dat_t mac(
    input dat_t a,
    input dat_t w,
    input dat_t yin
  );
    logic signed [2*WIDTH-1:0] p;
`ifdef SYSTOLIC_SATURATE_EN
    logic signed [2*WIDTH-1:0] t;
    logic signed [WIDTH:0]     s;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(w);
    t = p >>> FRAC_BIT;
    if (t > TMAX) t = TMAX;
    else if (t < TMIN) t = TMIN;
    s = {t[WIDTH-1], t[WIDTH-1:0]}
      + {yin[WIDTH-1], yin};
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return dat_t'(s[WIDTH-1:0]);
`else
    p = (2*WIDTH)'(a) * (2*WIDTH)'(w);
    return dat_t'(p >>> FRAC_BIT) + yin;
`endif
  endfunction

  assign out_valid = vld[D-1];
  assign stall     = out_valid && !out_ready;
  assign adv       = !stall;
  assign w_ready   = (state == IDLE) || (state == LOAD);
  assign in_ready  = (state == RUN) && !stall && !w_valid;
  assign w_hs      = w_valid && w_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state != IDLE) || (occ != '0);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0 && i == 0) begin : g_a0
        assign pe_a[i][j] = a_r[i];
      end else if (j == 0) begin : g_ask
        assign pe_a[i][j] = sk[i][i-1];
      end else begin : g_ah
        assign pe_a[i][j] = a_h[i][j-1];
      end
      if (i == 0) begin : g_s0
        assign pe_s[i][j] =
          mac(pe_a[i][j], wm[i][j], '0);
      end else begin : g_sn
        assign pe_s[i][j] =
          mac(pe_a[i][j], wm[i][j], ps[i-1][j]);
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    if (j == N-1) begin : g_last
      assign y_out[j*WIDTH +: WIDTH] = ps[N-1][j];
    end else begin : g_dsk
      assign y_out[j*WIDTH +: WIDTH] = dk[j][N-2-j];
    end
  end

  // control state, row counter and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      occ   <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      occ   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      occ   <= occ + OW'(in_hs) - OW'(out_hs);
    end
  end

  // next state: load rows, run, drain before reload
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE, LOAD: begin
        if (w_hs) begin
          if (cnt == CW'(N-1)) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            state_nx = LOAD;
            cnt_nx   = cnt + CW'(1);
          end
        end
      end
      RUN: begin
        if (w_valid) state_nx = DRAIN;
      end
      DRAIN: begin
        if (occ == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // weights, lockstep pipeline and valid tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < N; i++) begin
        a_r[i] <= '0;
        for (int j = 0; j < N; j++) begin
          wm[i][j]  <= '0;
          sk[i][j]  <= '0;
          a_h[i][j] <= '0;
          ps[i][j]  <= '0;
          dk[i][j]  <= '0;
        end
      end
    end else if (clr) begin
      vld <= '0;
      for (int i = 0; i < N; i++) begin
        a_r[i] <= '0;
        for (int j = 0; j < N; j++) begin
          wm[i][j]  <= '0;
          sk[i][j]  <= '0;
          a_h[i][j] <= '0;
          ps[i][j]  <= '0;
          dk[i][j]  <= '0;
        end
      end
    end else begin
      if (w_hs) begin
        for (int j = 0; j < N; j++)
          wm[cnt][j] <= w_row[j*WIDTH +: WIDTH];
      end
      if (adv) begin
        vld <= {vld[D-2:0], in_hs};
        for (int i = 0; i < N; i++) begin
          a_r[i] <= in_hs ? a_in[i*WIDTH +: WIDTH] : '0;
          sk[i][0] <= a_r[i];
          for (int k = 1; k < N; k++)
            sk[i][k] <= sk[i][k-1];
          for (int j = 0; j < N; j++) begin
            a_h[i][j] <= pe_a[i][j];
            ps[i][j]  <= pe_s[i][j];
          end
        end
        for (int j = 0; j < N; j++) begin
          dk[j][0] <= ps[N-1][j];
          for (int k = 1; k < N; k++)
            dk[j][k] <= dk[j][k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_nxn_ws.sv
// Bench for systolic_nxn_ws (N=2, WIDTH=16, FRAC_BIT=10).
// Scoreboard queue filled on input handshake, drained on output.
module tb_systolic_nxn_ws;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int VW = N*W;

  logic          clk = 1'b0;
  logic          rst_n, clr;
  logic          w_valid, w_ready;
  logic          in_valid, in_ready;
  logic          out_valid, out_ready, busy;
  logic [VW-1:0] w_row, a_in, y_out;

  always #5 clk = ~clk;

  systolic_nxn_ws #(.N(N), .WIDTH(W), .FRAC_BIT(10)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int n_out = 0;
  int n0;
  logic [VW-1:0] cur_exp;
  logic [VW-1:0] hold;
  logic [VW-1:0] exp_q [$];
  int acc_q [$];
  int stl_q [$];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input int a0,
                                        input int a1);
    return {a1[W-1:0], a0[W-1:0]};
  endfunction

  // scoreboard: push on accept, pop and compare on output
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", 1, 0);
      end else begin
        chk("y", y_out, exp_q.pop_front());
        chk("lat", cyc - acc_q.pop_front(),
            2*N + stall_cnt - stl_q.pop_front());
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc);
      stl_q.push_back(stall_cnt);
    end
    if (out_valid && !out_ready) stall_cnt++;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int w0, input int w1);
    bit ok = 1'b0;
    w_row   = vec(w0, w1);
    w_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (w_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("w_timeout", 0, 1);
    sync();
    w_valid = 1'b0;
  endtask

  task automatic send(input logic [VW-1:0] a,
                      input logic [VW-1:0] e);
    bit ok = 1'b0;
    a_in     = a;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    sync();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w_row = '0; a_in = '0; cur_exp = '0;
    #12;
    chk("rst_ov", out_valid, 0);
    chk("rst_y", y_out, 0);
    chk("rst_ir", in_ready, 0);
    chk("rst_wr", w_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();

    // identity weights
    load_row(1024, 0);
    @(negedge clk);
    chk("load_wr", w_ready, 1);
    chk("load_ir", in_ready, 0);
    sync();
    load_row(0, 1024);
    @(negedge clk);
    chk("run_ir", in_ready, 1);
    chk("run_wr", w_ready, 0);
    chk("run_busy", busy, 1);
    sync();
    send(vec(1024, 2048), vec(1024, 2048));
    wait_empty();

    // (1,2 / 3,4) weights, reload goes through DRAIN
    load_row(1024, 2048);
    load_row(3072, 4096);
    send(vec(1024, 1024), vec(4096, 6144));
    send(vec(-1024, 512), vec(512, 0));
    wait_empty();

    // 8 back-to-back vectors with a 3-cycle stall
    n0 = n_out;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(vec(k*1024, 1024),
               vec(1024*(k+3), 2048*k + 4096));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = y_out;
        chk("stall_ov", out_valid, 1);
        chk("stall_ir", in_ready, 0);
        repeat (2) begin
          @(negedge clk);
          chk("stall_ir", in_ready, 0);
          chk("stall_y", y_out, hold);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("stream_n", n_out - n0, 8);

    // weight request with 3 vectors in flight
    n0 = n_out;
    for (int k = 1; k <= 3; k++)
      send(vec(1024*k, 0), vec(1024*k, 2048*k));
    w_row   = vec(2048, 0);
    w_valid = 1'b1;
    @(negedge clk);
    chk("drain_ir", in_ready, 0);
    chk("drain_wr", w_ready, 0);
    chk("drain_busy", busy, 1);
    load_row(2048, 0);
    chk("drain_q", exp_q.size(), 0);
    chk("drain_n", n_out - n0, 3);
    load_row(0, 2048);
    send(vec(1024, -1024), vec(2048, -2048));
    wait_empty();

    // overflow boundary, all weights 1.0
    load_row(1024, 1024);
    load_row(1024, 1024);
`ifdef SYSTOLIC_SATURATE_EN
    send(vec(16384, 16384), vec(32767, 32767));
`else
    send(vec(16384, 16384), vec(-32768, -32768));
`endif
    send(vec(-16384, -16384), vec(-32768, -32768));
    send(vec(16384, -16384), vec(0, 0));
    wait_empty();

    // async reset while results are pending
    send(vec(1024, 1024), vec(2048, 2048));
    send(vec(512, 512), vec(1024, 1024));
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_ov", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr", w_ready, 1);
    chk("arst_ir", in_ready, 0);
    chk("arst_y", y_out, 0);
    exp_q.delete();
    acc_q.delete();
    stl_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sync();

    // clr during LOAD restarts from row 0
    load_row(1024, 0);
    clr = 1'b1;
    sync();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_wr", w_ready, 1);
    chk("clr_busy", busy, 0);
    sync();
    load_row(2048, 0);
    @(negedge clk);
    chk("clr_cnt", w_ready, 1);
    sync();
    load_row(0, 2048);
    send(vec(1024, 512), vec(2048, 1024));
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
